// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and constants for the countdown timer controller and its digit chain.
package countdown_timer_ctrl_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Bus between game control, the timer controller and the cascaded BCD digits.
interface countdown_timer_ctrl_if
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int N_DIGITS = 4
);

    logic                         load;
    logic [NIBBLE_W*N_DIGITS-1:0] load_value;
    logic                         start;
    logic                         stop;
    logic [NIBBLE_W*N_DIGITS-1:0] digit_value;
    logic [N_DIGITS-1:0]          digit_borrow_req;
    logic                         digit0_timeout;
    logic                         digit_load;
    logic [NIBBLE_W*N_DIGITS-1:0] digit_bin;
    logic [N_DIGITS-1:0]          digit_dec;
    logic [N_DIGITS-1:0]          digit_borrow_disable;
    logic                         running;
    logic                         done;
    logic                         done_pulse;

    modport slave (
        input  load, load_value, start, stop,
        input  digit_value, digit_borrow_req, digit0_timeout,
        output digit_load, digit_bin, digit_dec, digit_borrow_disable,
        output running, done, done_pulse
    );

    modport master (
        output load, load_value, start, stop,
        output digit_value, digit_borrow_req, digit0_timeout,
        input  digit_load, digit_bin, digit_dec, digit_borrow_disable,
        input  running, done, done_pulse
    );

endinterface

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
// Free-running divider that emits one tick every TICK_DIV enabled cycles and holds while disabled.
module tick_prescaler
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] count_q;

    assign tick_o = enable_i && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            if (count_q == LAST) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Control end of the BCD countdown chain: run/pause/done FSM, decrement prescaler,
// borrow forwarding between digits and borrow inhibit for the leading zeros.
module countdown_timer_ctrl
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    countdown_timer_ctrl_if.slave  bus
);

    state_t                       state_q, state_d;
    logic [NIBBLE_W*N_DIGITS-1:0] digitBin_q;
    logic                         digitLoad_q;
    logic                         running_q;
    logic                         done_q;
    logic                         donePulse_q;
    logic                         prescEnable;
    logic                         tick;
    logic [N_DIGITS-1:0]          digitDec;
    logic [N_DIGITS-1:0]          borrowDisable;

    // Time-out beats a tick in the same cycle, and stop suppresses that cycle's tick.
    assign prescEnable = (state_q == RUN) && !bus.load && !bus.stop && !bus.digit0_timeout;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable_i (prescEnable),
        .clear_i  (bus.load),
        .tick_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD:    state_d = IDLE;
                IDLE:    if (bus.start) state_d = RUN;
                RUN:     if (bus.stop) state_d = PAUSE;
                         else if (bus.digit0_timeout) state_d = DONE;
                PAUSE:   if (!bus.stop && bus.start) state_d = RUN;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            digitBin_q  <= '0;
            digitLoad_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            donePulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (bus.load) begin
                digitBin_q <= bus.load_value;
            end
            digitLoad_q <= (state_d == LOAD);
            running_q   <= (state_d == RUN);
            done_q      <= (state_d == DONE);
            donePulse_q <= (state_q == RUN) && (state_d == DONE);
        end
    end

    // Each digit's borrow request becomes the next digit's decrement, one cycle of ripple per stage.
    always_comb begin
        digitDec    = '0;
        digitDec[0] = tick;
        if (state_q != LOAD) begin
            for (int i = 1; i < N_DIGITS; i++) begin
                digitDec[i] = bus.digit_borrow_req[i-1];
            end
        end
    end

    always_comb begin
        borrowDisable = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            for (int j = i + 1; j < N_DIGITS; j++) begin
                if (bus.digit_value[j*NIBBLE_W +: NIBBLE_W] != '0) begin
                    borrowDisable[i] = 1'b0;
                end
            end
        end
    end

    assign bus.digit_load           = digitLoad_q;
    assign bus.digit_bin            = digitBin_q;
    assign bus.digit_dec            = digitDec;
    assign bus.digit_borrow_disable = borrowDisable;
    assign bus.running              = running_q;
    assign bus.done                 = done_q;
    assign bus.done_pulse           = donePulse_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench: a behavioural 4-digit BCD countdown chain around countdown_timer_ctrl.
module tb_countdown_timer_ctrl;
    import countdown_timer_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int TD = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clk = ~clk;

    countdown_timer_ctrl_if #(.N_DIGITS(N)) busIf ();

    countdown_timer_ctrl #(
        .N_DIGITS (N),
        .TICK_DIV (TD),
        .DIV_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    logic [3:0]   dv [N];
    logic [N-1:0] breq;

    // Digit chain model: load clamps to 9, a decrement at zero wraps to 9 and borrows unless inhibited.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            breq[i] <= 1'b0;
            if (!rst) begin
                dv[i] <= 4'd0;
            end else if (busIf.digit_load) begin
                dv[i] <= (busIf.digit_bin[i*4 +: 4] > BCD_MAX) ? BCD_MAX : busIf.digit_bin[i*4 +: 4];
            end else if (busIf.digit_dec[i]) begin
                if (dv[i] != 4'd0) begin
                    dv[i] <= dv[i] - 4'd1;
                end else if (!busIf.digit_borrow_disable[i]) begin
                    dv[i]   <= BCD_MAX;
                    breq[i] <= 1'b1;
                end
            end
        end
    end

    assign busIf.digit_value      = {dv[3], dv[2], dv[1], dv[0]};
    assign busIf.digit_borrow_req = breq;
    assign busIf.digit0_timeout   = (dv[0] == 4'd0) && busIf.digit_borrow_disable[0];

    typedef struct {
        logic        load;
        logic [15:0] lv;
        logic        start;
        logic        stop;
        logic        expLoad;
        logic        expRun;
        logic        expDone;
        logic        expPulse;
        logic [15:0] expDigits;
        logic [3:0]  expDec;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] lv, input logic st, input logic sp);
        busIf.load       = ld;
        busIf.load_value = lv;
        busIf.start      = st;
        busIf.stop       = sp;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadAndIdle(input logic [15:0] lv);
        applyStimulus(1'b1, lv, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        cycle();
    endtask

    initial begin
        int          k;
        int          numDec;
        int          badInterval;
        int          firstTo;
        int          kPulse;
        logic [15:0] lastDigits;
        logic [15:0] seen [$];
        logic [15:0] expSeq [$];
        int          seqBad;

        vecs[0]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 4'h0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 4'h0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 4'h0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 4'h0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 4'h0};
        vecs[6]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 4'h0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 4'h0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0};
        vecs[12] = '{1'b1, 16'h00F3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0093, 4'h0};

        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle();
        cycle();
        checkOutput("reset_running", 32'(busIf.running), 32'd0);
        checkOutput("reset_done", 32'(busIf.done), 32'd0);
        checkOutput("reset_bin", 32'(busIf.digit_bin), 32'd0);
        rst = 1'b1;

        $display("[TB] table-driven FSM vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].load, vecs[i].lv, vecs[i].start, vecs[i].stop);
            cycle();
            checkOutput($sformatf("vec%0d_load", i), 32'(busIf.digit_load), 32'(vecs[i].expLoad));
            checkOutput($sformatf("vec%0d_running", i), 32'(busIf.running), 32'(vecs[i].expRun));
            checkOutput($sformatf("vec%0d_done", i), 32'(busIf.done), 32'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d_pulse", i), 32'(busIf.done_pulse), 32'(vecs[i].expPulse));
            checkOutput($sformatf("vec%0d_digits", i), 32'(busIf.digit_value), 32'(vecs[i].expDigits));
            checkOutput($sformatf("vec%0d_dec", i), 32'(busIf.digit_dec), 32'(vecs[i].expDec));
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of RUN");
        loadAndIdle(16'h0123);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (3) cycle();
        checkOutput("midrun_running", 32'(busIf.running), 32'd1);
        rst = 1'b0;
        cycle();
        checkOutput("rst_load", 32'(busIf.digit_load), 32'd0);
        checkOutput("rst_running", 32'(busIf.running), 32'd0);
        checkOutput("rst_done", 32'(busIf.done), 32'd0);
        checkOutput("rst_pulse", 32'(busIf.done_pulse), 32'd0);
        checkOutput("rst_bin", 32'(busIf.digit_bin), 32'd0);
        checkOutput("rst_dec", 32'(busIf.digit_dec), 32'd0);
        rst = 1'b1;
        cycle();
        checkOutput("rst_digits", 32'(busIf.digit_value), 32'd0);
        checkOutput("rst_idle", 32'(busIf.running), 32'd0);

        $display("[TB] count down from 0012");
        loadAndIdle(16'h0012);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        expSeq = '{16'h0011, 16'h0010, 16'h0019, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                   16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
        seen.delete();
        lastDigits  = 16'h0012;
        numDec      = 0;
        badInterval = 0;
        firstTo     = -1;
        kPulse      = -1;
        k           = 1;
        while (k <= 200) begin
            if (busIf.digit_dec[0]) begin
                numDec++;
                if ((k % TD) != 0) badInterval++;
            end
            if (busIf.digit_value != lastDigits) begin
                seen.push_back(busIf.digit_value);
                lastDigits = busIf.digit_value;
            end
            if (busIf.digit0_timeout && firstTo < 0) firstTo = k;
            if (busIf.done_pulse && kPulse < 0) kPulse = k;
            if (busIf.done) break;
            cycle();
            k++;
        end
        checkOutput("cd_done_reached", 32'(busIf.done), 32'd1);
        checkOutput("cd_num_dec", 32'(numDec), 32'd12);
        checkOutput("cd_tick_interval_errors", 32'(badInterval), 32'd0);
        checkOutput("cd_seq_len", 32'(seen.size()), 32'(expSeq.size()));
        seqBad = 0;
        for (int i = 0; i < expSeq.size() && i < seen.size(); i++) begin
            if (seen[i] != expSeq[i]) seqBad++;
        end
        checkOutput("cd_seq_errors", 32'(seqBad), 32'd0);
        checkOutput("cd_pulse_after_timeout", 32'(kPulse - firstTo), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        repeat (3) cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("cd_done_holds", 32'(busIf.done), 32'd1);
        checkOutput("cd_pulse_once", 32'(busIf.done_pulse), 32'd0);
        checkOutput("cd_running_in_done", 32'(busIf.running), 32'd0);

        $display("[TB] borrow ripple from 1000");
        loadAndIdle(16'h1000);
        checkOutput("rip_bd_initial", 32'(busIf.digit_borrow_disable), 32'h8);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        k = 0;
        while (!busIf.digit_dec[0] && k < 20) begin
            cycle();
            k++;
        end
        checkOutput("rip_tick_seen", 32'(busIf.digit_dec[0]), 32'd1);
        cycle();
        checkOutput("rip_step1", 32'(busIf.digit_value), 32'h1009);
        cycle();
        checkOutput("rip_step2", 32'(busIf.digit_value), 32'h1099);
        cycle();
        checkOutput("rip_step3", 32'(busIf.digit_value), 32'h1999);
        cycle();
        checkOutput("rip_step4", 32'(busIf.digit_value), 32'h0999);
        checkOutput("rip_bd_0999", 32'(busIf.digit_borrow_disable), 32'hC);

        $display("[TB] pause and resume from 0005");
        loadAndIdle(16'h0005);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (3) cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("pause_running", 32'(busIf.running), 32'd0);
        numDec = 0;
        for (int i = 0; i < 20; i++) begin
            if (busIf.digit_dec[0]) numDec++;
            cycle();
        end
        checkOutput("pause_no_dec", 32'(numDec), 32'd0);
        checkOutput("pause_digits", 32'(busIf.digit_value), 32'h0005);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        k = 1;
        while (!busIf.digit_dec[0] && k < 20) begin
            cycle();
            k++;
        end
        checkOutput("resume_first_tick", 32'(k), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
